// File: rtl/plcp_header_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : plcp_header_decoder
//  Purpose  : 802.11b long-preamble PLCP receiver. Locks on SYNC ones, hunts
//             for the SFD, captures and CRC-checks the 48-bit PLCP header,
//             then forwards 1 Mbit/s PSDU bits one per enabled clock.
//  Revision : 1.0  initial release
// ============================================================================
module plcp_header_decoder #(
   parameter int          SYNC_MIN    = 16,
   parameter int          SFD_TIMEOUT = 160,
   parameter logic [15:0] SFD_PATTERN = 16'hF3A0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        bit_in,
   output logic [1:0]  state_out,
   output logic        sfd_found,
   output logic [7:0]  signal_out,
   output logic [7:0]  service_out,
   output logic [15:0] length_out,
   output logic        header_valid,
   output logic        header_error,
   output logic        payload_bit,
   output logic        payload_valid,
   output logic        frame_end
);

   localparam logic [1:0] ST_SYNC    = 2'd0;
   localparam logic [1:0] ST_HUNT    = 2'd1;
   localparam logic [1:0] ST_HEADER  = 2'd2;
   localparam logic [1:0] ST_PAYLOAD = 2'd3;

   localparam int ONES_W = $clog2(SYNC_MIN + 1);
   localparam int HUNT_W = $clog2(SFD_TIMEOUT + 1);

   localparam logic [ONES_W-1:0] C_SYNC_MIN  = ONES_W'(SYNC_MIN);
   localparam logic [HUNT_W-1:0] C_HUNT_LAST = HUNT_W'(SFD_TIMEOUT - 1);
   localparam logic [5:0]        C_HDR_CRC0  = 6'd32;   // first received-CRC bit
   localparam logic [5:0]        C_HDR_LAST  = 6'd47;   // last header bit
   localparam logic [15:0]       C_CRC_POLY  = 16'h1021;
   localparam logic [7:0]        C_RATE_1M   = 8'h0A;

   logic [1:0]        state_q,  state_d;
   logic [15:0]       sr_q,     sr_d;
   logic [ONES_W-1:0] ones_q,   ones_d;
   logic [HUNT_W-1:0] hunt_q,   hunt_d;
   logic [5:0]        hcnt_q,   hcnt_d;
   logic [31:0]       hdr_q,    hdr_d;
   logic [15:0]       crc_q,    crc_d;
   logic [15:0]       rxcrc_q,  rxcrc_d;
   logic [15:0]       pcnt_q,   pcnt_d;
   logic [7:0]        sig_q,    sig_d;
   logic [7:0]        srv_q,    srv_d;
   logic [15:0]       len_q,    len_d;
   logic              pbit_q,   pbit_d;
   logic              pvld_q,   pvld_d;
   logic              sfd_q,    sfd_d;
   logic              hv_q,     hv_d;
   logic              he_q,     he_d;
   logic              fe_q,     fe_d;

   logic [15:0]       w_sr_next;
   logic [ONES_W-1:0] w_ones_inc;
   logic              w_fb;
   logic [15:0]       w_rx_full;

   // Next-state logic: everything advances only on enabled edges; pulses default low
   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      ones_d     = ones_q;
      hunt_d     = hunt_q;
      hcnt_d     = hcnt_q;
      hdr_d      = hdr_q;
      crc_d      = crc_q;
      rxcrc_d    = rxcrc_q;
      pcnt_d     = pcnt_q;
      sig_d      = sig_q;
      srv_d      = srv_q;
      len_d      = len_q;
      pbit_d     = pbit_q;
      pvld_d     = 1'b0;
      sfd_d      = 1'b0;
      hv_d       = 1'b0;
      he_d       = 1'b0;
      fe_d       = 1'b0;
      w_sr_next  = {bit_in, sr_q[15:1]};
      w_ones_inc = (ones_q == C_SYNC_MIN) ? ones_q : ones_q + 1'b1;
      w_fb       = bit_in ^ crc_q[15];
      w_rx_full  = {rxcrc_q[14:0], bit_in};

      if (enable) begin
         sr_d = w_sr_next;
         case (state_q)
            ST_SYNC: begin
               ones_d = bit_in ? w_ones_inc : '0;
               if (bit_in && (w_ones_inc == C_SYNC_MIN)) begin
                  state_d = ST_HUNT;
                  hunt_d  = '0;
               end
            end
            ST_HUNT: begin
               // Window includes the bit arriving on this edge
               if (w_sr_next == SFD_PATTERN) begin
                  sfd_d   = 1'b1;
                  state_d = ST_HEADER;
                  hcnt_d  = '0;
                  crc_d   = 16'hFFFF;
                  rxcrc_d = '0;
               end else if (hunt_q == C_HUNT_LAST) begin
                  state_d = ST_SYNC;
                  ones_d  = '0;
                  hunt_d  = '0;
               end else begin
                  hunt_d = hunt_q + 1'b1;
               end
            end
            ST_HEADER: begin
               hcnt_d = hcnt_q + 1'b1;
               if (hcnt_q < C_HDR_CRC0) begin
                  // Fields arrive LSB first, so shift in from the top
                  hdr_d = {bit_in, hdr_q[31:1]};
                  crc_d = {crc_q[14:0], 1'b0} ^ (w_fb ? C_CRC_POLY : 16'h0000);
               end else begin
                  rxcrc_d = w_rx_full;
               end
               if (hcnt_q == C_HDR_LAST) begin
                  ones_d  = '0;
                  state_d = ST_SYNC;
                  if (w_rx_full == ~crc_q) begin
                     hv_d  = 1'b1;
                     sig_d = hdr_q[7:0];
                     srv_d = hdr_q[15:8];
                     len_d = hdr_q[31:16];
                     if ((hdr_q[7:0] == C_RATE_1M) && (hdr_q[31:16] != 16'h0000)) begin
                        state_d = ST_PAYLOAD;
                        pcnt_d  = hdr_q[31:16];
                     end else begin
                        fe_d = 1'b1;
                     end
                  end else begin
                     he_d = 1'b1;
                  end
               end
            end
            default: begin
               // PAYLOAD: forward bits without any SFD search
               pbit_d = bit_in;
               pvld_d = 1'b1;
               pcnt_d = pcnt_q - 1'b1;
               if (pcnt_q == 16'd1) begin
                  fe_d    = 1'b1;
                  state_d = ST_SYNC;
                  ones_d  = '0;
               end
            end
         endcase
      end
   end

   // State and output registers with asynchronous clear
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_SYNC;
         sr_q    <= '0;
         ones_q  <= '0;
         hunt_q  <= '0;
         hcnt_q  <= '0;
         hdr_q   <= '0;
         crc_q   <= '0;
         rxcrc_q <= '0;
         pcnt_q  <= '0;
         sig_q   <= '0;
         srv_q   <= '0;
         len_q   <= '0;
         pbit_q  <= 1'b0;
         pvld_q  <= 1'b0;
         sfd_q   <= 1'b0;
         hv_q    <= 1'b0;
         he_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         ones_q  <= ones_d;
         hunt_q  <= hunt_d;
         hcnt_q  <= hcnt_d;
         hdr_q   <= hdr_d;
         crc_q   <= crc_d;
         rxcrc_q <= rxcrc_d;
         pcnt_q  <= pcnt_d;
         sig_q   <= sig_d;
         srv_q   <= srv_d;
         len_q   <= len_d;
         pbit_q  <= pbit_d;
         pvld_q  <= pvld_d;
         sfd_q   <= sfd_d;
         hv_q    <= hv_d;
         he_q    <= he_d;
         fe_q    <= fe_d;
      end
   end

   assign state_out     = state_q;
   assign sfd_found     = sfd_q;
   assign signal_out    = sig_q;
   assign service_out   = srv_q;
   assign length_out    = len_q;
   assign header_valid  = hv_q;
   assign header_error  = he_q;
   assign payload_bit   = pbit_q;
   assign payload_valid = pvld_q;
   assign frame_end     = fe_q;

endmodule
`default_nettype wire

// File: tb/tb_plcp_header_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_plcp_header_decoder
//  Purpose  : Self-checking bench: table of frame scenarios plus randomized
//             frames, compared edge by edge against a stream-scanning model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_plcp_header_decoder;

   localparam int MAXB = 4096;
   localparam int NROW = 7;

   logic        clock, reset, enable, bit_in;
   logic [1:0]  state_out;
   logic        sfd_found, header_valid, header_error;
   logic        payload_bit, payload_valid, frame_end;
   logic [7:0]  signal_out, service_out;
   logic [15:0] length_out;

   plcp_header_decoder dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .bit_in       (bit_in),
      .state_out    (state_out),
      .sfd_found    (sfd_found),
      .signal_out   (signal_out),
      .service_out  (service_out),
      .length_out   (length_out),
      .header_valid (header_valid),
      .header_error (header_error),
      .payload_bit  (payload_bit),
      .payload_valid(payload_valid),
      .frame_end    (frame_end)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int          ones;
      bit          gap0;
      bit          sfd;
      int          alt;
      bit          hdr;
      logic [7:0]  sig;
      logic [7:0]  srv;
      logic [15:0] len;
      int          flip;
      int          pay;
      bit          tog;
      int          x_sfd, x_hv, x_he, x_pv, x_fe;
      logic [7:0]  x_sig;
      logic [15:0] x_len;
   } vec_t;

   vec_t vt [NROW];

   // stimulus stream and per-bit expectations
   bit          strm [MAXB];
   bit          idl  [MAXB];
   int          rid  [MAXB];
   int          nb;
   int          cur_row;
   logic [1:0]  e_st [MAXB];
   logic [4:0]  e_pl [MAXB];   // {sfd, hv, he, fe, pv}
   bit          e_pb [MAXB];
   logic [7:0]  e_sig[MAXB];
   logic [7:0]  e_srv[MAXB];
   logic [15:0] e_len[MAXB];
   logic [7:0]  m_sig, m_srv;
   logic [15:0] m_len;

   int a_sfd[NROW+1], a_hv[NROW+1], a_he[NROW+1], a_pv[NROW+1], a_fe[NROW+1];
   logic [7:0]  a_sig[NROW+1];
   logic [15:0] a_len[NROW+1];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic logic [15:0] crc16(input logic [31:0] d);
      logic [15:0] c;
      bit fb;
      c = 16'hFFFF;
      for (int i = 0; i < 32; i++) begin
         fb = d[i] ^ c[15];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   function automatic logic [39:0] pack_act();
      return {state_out, sfd_found, header_valid, header_error, frame_end, payload_valid,
              payload_valid & payload_bit, signal_out, service_out, length_out};
   endfunction

   function automatic logic [39:0] pack_exp(input int k, input bit idle);
      if (idle) return {e_st[k], 5'b0, 1'b0, e_sig[k], e_srv[k], e_len[k]};
      return {e_st[k], e_pl[k], e_pb[k], e_sig[k], e_srv[k], e_len[k]};
   endfunction

   task automatic push(input bit b, input bit tg);
      strm[nb] = b;
      idl[nb]  = tg ? 1'b1 : ($urandom_range(0, 7) == 0);
      rid[nb]  = cur_row;
      nb++;
   endtask

   task automatic push_header(input logic [7:0] s, input logic [7:0] v, input logic [15:0] l,
                              input int flip, input bit tg);
      logic [47:0] hb;
      logic [31:0] d;
      logic [15:0] c;
      d = {l, v, s};
      c = ~crc16(d);
      hb[31:0] = d;
      for (int i = 0; i < 16; i++) hb[32+i] = c[15-i];
      if (flip >= 0) hb[flip] = ~hb[flip];
      for (int i = 0; i < 48; i++) push(hb[i], tg);
   endtask

   task automatic push_row(input vec_t v);
      logic [15:0] sfdv;
      sfdv = 16'hF3A0;
      repeat (8) push(1'b0, v.tog);
      repeat (v.ones) push(1'b1, v.tog);
      if (v.gap0) push(1'b0, v.tog);
      if (v.sfd) for (int i = 0; i < 16; i++) push(sfdv[i], v.tog);
      for (int i = 0; i < v.alt; i++) push((i % 2) == 0, v.tog);
      if (v.hdr) push_header(v.sig, v.srv, v.len, v.flip, v.tog);
      for (int i = 0; i < v.pay; i++) push(1'(($urandom_range(0, 1))), v.tog);
   endtask

   task automatic put(input int k, input logic [1:0] st, input logic [4:0] pl);
      e_st[k]  = st;
      e_pl[k]  = pl;
      e_pb[k]  = pl[0] ? strm[k] : 1'b0;
      e_sig[k] = m_sig;
      e_srv[k] = m_srv;
      e_len[k] = m_len;
   endtask

   // Scan the whole stream phase by phase: sync run, SFD window search, header, payload
   task automatic build_model(input int n);
      int p, run, h, idx;
      bit found;
      logic [15:0] win, rx;
      logic [31:0] d;
      m_sig = '0; m_srv = '0; m_len = '0;
      p = 0;
      while (p < n) begin
         run = 0;
         while (p < n && run < 16) begin
            run = strm[p] ? run + 1 : 0;
            put(p, (run == 16) ? 2'd1 : 2'd0, 5'b0);
            p++;
         end
         found = 1'b0;
         h = 0;
         while (p < n && !found && h < 160) begin
            h++;
            for (int i = 0; i < 16; i++) begin
               idx = p - 15 + i;
               win[i] = (idx >= 0) ? strm[idx] : 1'b0;
            end
            if (win == 16'hF3A0) begin
               found = 1'b1;
               put(p, 2'd2, 5'b10000);
            end else begin
               put(p, (h == 160) ? 2'd0 : 2'd1, 5'b0);
            end
            p++;
         end
         if (!found) continue;
         if (p + 48 > n) begin
            while (p < n) begin put(p, 2'd2, 5'b0); p++; end
         end else begin
            for (int i = 0; i < 32; i++) d[i] = strm[p+i];
            rx = '0;
            for (int i = 0; i < 16; i++) rx = {rx[14:0], strm[p+32+i]};
            for (int i = 0; i < 47; i++) put(p + i, 2'd2, 5'b0);
            p += 47;
            if (rx == ~crc16(d)) begin
               m_sig = d[7:0]; m_srv = d[15:8]; m_len = d[31:16];
               if (m_sig == 8'h0A && m_len != 16'h0000) begin
                  put(p, 2'd3, 5'b01000);
                  p++;
                  for (int i = 0; i < int'(m_len) && p < n; i++) begin
                     if (i == int'(m_len) - 1) put(p, 2'd0, 5'b00011);
                     else                      put(p, 2'd3, 5'b00001);
                     p++;
                  end
               end else begin
                  put(p, 2'd0, 5'b01010);
                  p++;
               end
            end else begin
               put(p, 2'd0, 5'b00100);
               p++;
            end
         end
      end
   endtask

   task automatic run_stream();
      int r;
      for (int k = 0; k < nb; k++) begin
         @(negedge clock);
         enable = 1'b1;
         bit_in = strm[k];
         @(posedge clock);
         #1;
         chk($sformatf("edge%0d", k), {24'b0, pack_act()}, {24'b0, pack_exp(k, 1'b0)});
         r = rid[k];
         a_sfd[r] += int'(sfd_found);
         a_hv[r]  += int'(header_valid);
         a_he[r]  += int'(header_error);
         a_pv[r]  += int'(payload_valid);
         a_fe[r]  += int'(frame_end);
         a_sig[r]  = signal_out;
         a_len[r]  = length_out;
         if (idl[k]) begin
            @(negedge clock);
            enable = 1'b0;
            bit_in = 1'(($urandom_range(0, 1)));
            @(posedge clock);
            #1;
            chk($sformatf("idle%0d", k), {24'b0, pack_act()}, {24'b0, pack_exp(k, 1'b1)});
         end
      end
      @(negedge clock);
      enable = 1'b0;
   endtask

   initial begin
      logic [7:0] sigs [4];
      vec_t rv;
      sigs = '{8'h0A, 8'h14, 8'h37, 8'h6E};
      //          ones gap sfd alt hdr sig    srv    len       flip pay tog  sfd hv he pv fe  sig    len
      vt[0] = '{16, 1'b0, 1'b1,   0, 1'b1, 8'h0A, 8'h00, 16'h0010, -1, 16, 1'b0, 1, 1, 0, 16, 1, 8'h0A, 16'h0010};
      vt[1] = '{16, 1'b0, 1'b1,   0, 1'b1, 8'h0A, 8'h00, 16'h0010, 19,  0, 1'b0, 1, 0, 1,  0, 0, 8'h0A, 16'h0010};
      vt[2] = '{16, 1'b0, 1'b1,   0, 1'b1, 8'h14, 8'h00, 16'h0010, -1,  0, 1'b0, 1, 1, 0,  0, 1, 8'h14, 16'h0010};
      vt[3] = '{16, 1'b0, 1'b0, 200, 1'b0, 8'h00, 8'h00, 16'h0000, -1,  0, 1'b0, 0, 0, 0,  0, 0, 8'h14, 16'h0010};
      vt[4] = '{15, 1'b1, 1'b1,   0, 1'b0, 8'h00, 8'h00, 16'h0000, -1,  0, 1'b0, 0, 0, 0,  0, 0, 8'h14, 16'h0010};
      vt[5] = '{16, 1'b0, 1'b1,   0, 1'b1, 8'h0A, 8'h00, 16'h0008, -1,  8, 1'b0, 1, 1, 0,  8, 1, 8'h0A, 16'h0008};
      vt[6] = '{16, 1'b0, 1'b1,   0, 1'b1, 8'h0A, 8'h00, 16'h0010, -1, 16, 1'b1, 1, 1, 0, 16, 1, 8'h0A, 16'h0010};
      for (int r = 0; r <= NROW; r++) begin
         a_sfd[r] = 0; a_hv[r] = 0; a_he[r] = 0; a_pv[r] = 0; a_fe[r] = 0;
         a_sig[r] = '0; a_len[r] = '0;
      end

      reset  = 1'b1;
      enable = 1'b0;
      bit_in = 1'b0;
      repeat (2) @(negedge clock);
      chk("reset outputs", {24'b0, pack_act()}, 64'd0);
      chk("reset payload_bit", {63'b0, payload_bit}, 64'd0);
      reset = 1'b0;

      // Table scenarios followed by randomized frames, one continuous stream
      nb = 0;
      for (int r = 0; r < NROW; r++) begin
         cur_row = r;
         push_row(vt[r]);
      end
      cur_row = NROW;
      for (int f = 0; f < 8; f++) begin
         rv       = vt[0];
         rv.ones  = $urandom_range(16, 20);
         rv.sig   = sigs[$urandom_range(0, 3)];
         rv.srv   = 8'($urandom_range(0, 255));
         rv.len   = 16'($urandom_range(0, 20));
         rv.flip  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 47) : -1;
         rv.pay   = int'(rv.len);
         rv.tog   = 1'($urandom_range(0, 1));
         push_row(rv);
      end
      repeat (24) push(1'b0, 1'b0);
      build_model(nb);
      run_stream();

      for (int r = 0; r < NROW; r++) begin
         chk($sformatf("row%0d sfd_found count", r),     64'(a_sfd[r]), 64'(vt[r].x_sfd));
         chk($sformatf("row%0d header_valid count", r),  64'(a_hv[r]),  64'(vt[r].x_hv));
         chk($sformatf("row%0d header_error count", r),  64'(a_he[r]),  64'(vt[r].x_he));
         chk($sformatf("row%0d payload_valid count", r), 64'(a_pv[r]),  64'(vt[r].x_pv));
         chk($sformatf("row%0d frame_end count", r),     64'(a_fe[r]),  64'(vt[r].x_fe));
         chk($sformatf("row%0d signal_out", r),          64'(a_sig[r]), 64'(vt[r].x_sig));
         chk($sformatf("row%0d length_out", r),          64'(a_len[r]), 64'(vt[r].x_len));
      end

      // Reset asserted between clock edges while a payload is in flight
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      nb = 0;
      cur_row = NROW;
      vt[0].pay = 8;
      push_row(vt[0]);
      build_model(nb);
      run_stream();
      chk("pre-reset state_out", 64'(state_out), 64'd3);
      chk("pre-reset length_out", 64'(length_out), 64'h10);
      #3;
      reset = 1'b1;
      #1;
      chk("async reset outputs", {24'b0, pack_act()}, 64'd0);
      chk("async reset payload_bit", {63'b0, payload_bit}, 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clock);
         #1;
         chk($sformatf("reset hold %0d", i), {24'b0, pack_act()}, 64'd0);
      end
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         enable = 1'b1;
         bit_in = 1'b0;
         @(posedge clock);
         #1;
         chk($sformatf("post-reset %0d", i), {24'b0, pack_act()}, 64'd0);
      end
      @(negedge clock);
      enable = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
